// File: rtl/tree_level_stage_p.sv
`default_nettype none
// ============================================================================
// Module      : tree_level_stage_p
// Description : Two-lane decision-tree level stage. Extracts packet bits
//               selected by the node, looks up the child node in a dual-port
//               node memory and presents it 3 cycles later. Build option
//               TREE_LEVEL_WR_FWD_EN gives lane-1 write-first behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tree_level_stage_p #(
    parameter int PACKET_WIDTH = 104,
    parameter int NODE_WIDTH   = 40,
    parameter int NUM_EBITS    = 3,
    parameter int BIT_WIDTH    = 8,
    parameter int FIELD0_MSB   = 14,
    parameter int MASK_LSB     = 4,
    parameter int LEAF_BIT     = 0,
    parameter int NODE_ADDR    = 9,
    parameter int MEM_AW       = 6
) (
    input  logic                    clk,
    input  logic                    RSTn,
    input  logic [PACKET_WIDTH-1:0] packet_in1,
    input  logic                    data_valid_in1,
    input  logic [NODE_WIDTH-1:0]   node_in1,
    input  logic                    matched_in1,
    input  logic [PACKET_WIDTH-1:0] packet_in2,
    input  logic                    data_valid_in2,
    input  logic [NODE_WIDTH-1:0]   node_in2,
    input  logic                    matched_in2,
    output logic [PACKET_WIDTH-1:0] packet_out1,
    output logic                    data_valid_out1,
    output logic [NODE_WIDTH-1:0]   node_out1,
    output logic                    matched_out1,
    output logic [PACKET_WIDTH-1:0] packet_out2,
    output logic                    data_valid_out2,
    output logic [NODE_WIDTH-1:0]   node_out2,
    output logic                    matched_out2,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [MEM_AW-1:0]       upd_addr,
    input  logic [NODE_WIDTH-1:0]   upd_data
);

    localparam int c_SUM_W = ((NODE_ADDR > MEM_AW) ? NODE_ADDR : MEM_AW) + NUM_EBITS;

    // A right shift by a field value >= PACKET_WIDTH leaves bit 0 clear,
    // which gives the required zero Ebit for out-of-range positions.
    function automatic logic [MEM_AW-1:0] f_lookup_addr(
        input logic [PACKET_WIDTH-1:0] pkt,
        input logic [NODE_WIDTH-1:0]   node
    );
        logic [NUM_EBITS-1:0]    ebits;
        logic [BIT_WIDTH-1:0]    fld;
        logic [PACKET_WIDTH-1:0] shifted;
        logic [c_SUM_W-1:0]      sum;
        for (int k = 0; k < NUM_EBITS; k++) begin
            fld      = node[FIELD0_MSB + k*BIT_WIDTH -: BIT_WIDTH];
            shifted  = pkt >> fld;
            ebits[k] = shifted[0] & node[MASK_LSB + k];
        end
        sum = c_SUM_W'(node[NODE_WIDTH-1 -: NODE_ADDR]) + c_SUM_W'(ebits);
        return sum[MEM_AW-1:0];
    endfunction

    logic [PACKET_WIDTH-1:0] w_pkt_in  [2];
    logic [NODE_WIDTH-1:0]   w_node_in [2];
    logic                    w_vld_in  [2];
    logic                    w_mat_in  [2];
    logic [MEM_AW-1:0]       w_addr    [2];
    logic                    w_wr_en;

    logic [NODE_WIDTH-1:0]   mem [2**MEM_AW];
    logic [NODE_WIDTH-1:0]   rd_d      [2];
    logic [NODE_WIDTH-1:0]   rd_q      [2];

    logic [PACKET_WIDTH-1:0] pkt1_q [2], pkt2_q [2], pkt3_q [2];
    logic [NODE_WIDTH-1:0]   node1_q[2], node2_q[2], node3_q[2];
    logic                    vld1_q [2], vld2_q [2], vld3_q [2];
    logic                    mat1_q [2], mat2_q [2], mat3_q [2];
    logic [NODE_WIDTH-1:0]   rd2_q  [2];
    logic [NODE_WIDTH-1:0]   node3_d[2];
    logic                    mat3_d [2];

    assign w_pkt_in[0]  = packet_in1;
    assign w_pkt_in[1]  = packet_in2;
    assign w_node_in[0] = node_in1;
    assign w_node_in[1] = node_in2;
    assign w_vld_in[0]  = data_valid_in1;
    assign w_vld_in[1]  = data_valid_in2;
    assign w_mat_in[0]  = matched_in1;
    assign w_mat_in[1]  = matched_in2;

    // Lane 2 shares port B with updates and always wins.
    assign upd_ready = RSTn & ~data_valid_in2;
    assign w_wr_en   = upd_valid & upd_ready;

    always_comb begin
        for (int l = 0; l < 2; l++) begin
            w_addr[l] = f_lookup_addr(w_pkt_in[l], w_node_in[l]);
            rd_d[l]   = mem[w_addr[l]];
        end
`ifdef TREE_LEVEL_WR_FWD_EN
        if (w_wr_en && (upd_addr == w_addr[0])) begin
            rd_d[0] = upd_data;
        end
`endif
    end

    // Node memory and its address-stage read registers carry no reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem[upd_addr] <= upd_data;
        end
        for (int l = 0; l < 2; l++) begin
            rd_q[l] <= rd_d[l];
        end
    end

    always_comb begin
        for (int l = 0; l < 2; l++) begin
            node3_d[l] = mat2_q[l] ? node2_q[l] : rd2_q[l];
            mat3_d[l]  = mat2_q[l] | rd2_q[l][LEAF_BIT];
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            for (int l = 0; l < 2; l++) begin
                pkt1_q[l]  <= '0;
                pkt2_q[l]  <= '0;
                pkt3_q[l]  <= '0;
                node1_q[l] <= '0;
                node2_q[l] <= '0;
                node3_q[l] <= '0;
                vld1_q[l]  <= 1'b0;
                vld2_q[l]  <= 1'b0;
                vld3_q[l]  <= 1'b0;
                mat1_q[l]  <= 1'b0;
                mat2_q[l]  <= 1'b0;
                mat3_q[l]  <= 1'b0;
                rd2_q[l]   <= '0;
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                pkt1_q[l]  <= w_pkt_in[l];
                node1_q[l] <= w_node_in[l];
                vld1_q[l]  <= w_vld_in[l];
                mat1_q[l]  <= w_mat_in[l];
                pkt2_q[l]  <= pkt1_q[l];
                node2_q[l] <= node1_q[l];
                vld2_q[l]  <= vld1_q[l];
                mat2_q[l]  <= mat1_q[l];
                rd2_q[l]   <= rd_q[l];
                pkt3_q[l]  <= pkt2_q[l];
                node3_q[l] <= node3_d[l];
                vld3_q[l]  <= vld2_q[l];
                mat3_q[l]  <= mat3_d[l];
            end
        end
    end

    assign packet_out1     = pkt3_q[0];
    assign data_valid_out1 = vld3_q[0];
    assign node_out1       = node3_q[0];
    assign matched_out1    = mat3_q[0];
    assign packet_out2     = pkt3_q[1];
    assign data_valid_out2 = vld3_q[1];
    assign node_out2       = node3_q[1];
    assign matched_out2    = mat3_q[1];

endmodule
`default_nettype wire
